seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexing scan controller for the 4-digit common-anode seven-segment display on the stopwatch board. It snapshots four BCD digit codes once per scan frame and presents one code at a time to the hex-to-7-segment decoder. It drives the active-low anode lines and decimal point, with a dark guard interval between digits to suppress ghosting. Optional leading-zero blanking is included.

Parameters:
DIV, 100000, SHOW duration per digit in clk cycles (1 ms at 100 MHz); legal range 1..2^20-1.
GUARD, 1000, dark cycles before each digit; 0 means the GUARD state is skipped.

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
digits_in  in  16  four 4-bit codes; [3:0]=digit0 (rightmost) .. [15:12]=digit3
dp_in  in  4  decimal point request per digit, 1=lit; bit i = digit i
lz_blank  in  1  1=enable leading-zero blanking
digit_code  out  4  code to the 7-seg decoder; 4'hF = blank
an  out  4  anodes, active-low; bit i = digit i
dp  out  1  decimal point, active-low
frame_start  out  1  one-cycle pulse in the LOAD cycle

Behaviour:
- Single clock domain. Reset is synchronous and active-low; no asynchronous reset exists.
- While rst_n=0, all outputs are registered: an=4'b1111, digit_code=4'hF, dp=1, frame_start=0.
- While rst_n=0, internal state is: state=LOAD, idx=0, cnt=0, snapshot registers=0.
- State sequence per frame: LOAD, then for idx=0..3 GUARD(idx) -> SHOW(idx), then back to LOAD.
- Frame length = 1 + 4*(GUARD+DIV) cycles.
- LOAD lasts 1 cycle:
  - Captures digits_in, dp_in and lz_blank into the snapshot registers.
  - frame_start=1, an=1111, digit_code=F, dp=1.
  - Next state is GUARD(0), or SHOW(0) if GUARD=0.
- GUARD(idx) lasts GUARD cycles: an=1111, digit_code=F, dp=1.
- SHOW(idx) lasts DIV cycles:
  - If idx is not blanked: an[idx]=0 and all other anode bits=1; digit_code=snap_digit[idx]; dp=~snap_dp[idx].
  - If idx is blanked: an=1111, digit_code=F, dp=1.
- When SHOW(3) completes, the next state is LOAD. Otherwise idx increments and the next state is GUARD(idx+1).
- cnt resets to 0 on every state entry and is sized ceil(log2(max(DIV,GUARD,2))).
- Outputs are registered. They take the value belonging to a state on the same edge that enters that state. There is no added latency.
- Leading-zero blanking is evaluated on snapshot values and applies only when snap_lz=1:
  - digit3 is blanked if it is 0.
  - digit2 is blanked if digit3 and digit2 are both 0.
  - digit1 is blanked if digits 3, 2 and 1 are all 0.
  - digit0 is never blanked.
  - A blanked digit also suppresses its decimal point.
- Codes A..F in digits_in pass through unmodified; the decoder renders them blank.
- Input changes between LOAD cycles have no effect until the next LOAD. This guarantees no tearing within a frame.
- Reset asserted mid-frame takes effect at the next edge: outputs go dark immediately and the scan restarts at LOAD.
- Invariants: at most one an bit is low in any cycle, and an is never low in LOAD or GUARD.

Test Plan:
1. DIV=4, GUARD=2, lz_blank=0, digits_in=16'h1234, dp_in=0, release reset.
   - frame_start pulses once every 25 cycles.
   - Per digit: 2 cycles an=1111, then 4 cycles with an=1110/code 4, 1101/code 3, 1011/code 2, 0111/code 1.
   - dp=1 throughout.
2. digits_in=16'h0005, lz_blank=1, dp_in=4'b0100:
   - Digits 3, 2 and 1 stay dark (an=1111, code F, dp=1), including digit 2 despite its dp request.
   - Digit0 shows code 5.
   - Repeat with lz_blank=0: all four digits are driven, and digit2 has dp=0.
3. Change digits_in from 16'h1111 to 16'h2222 during SHOW(1):
   - Digits 1..3 still show 1 for the rest of the frame.
   - The next frame shows 2 on all digits from the LOAD cycle on.
4. GUARD=0, DIV=1:
   - an cycles LOAD(1111), 1110, 1101, 1011, 0111 with period 5.
   - frame_start high only in the LOAD cycle.
5. Assert rst_n=0 for one cycle during SHOW(2):
   - On the next edge an=1111, code F, dp=1, frame_start=0.
   - After release, the scan restarts with LOAD and then digit 0.
6. Random digits_in/dp_in over 1000 frames: the assertions "at most one an bit low" and "no anode low in LOAD/GUARD" never fail.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan of a 4-digit common-anode seven-segment
// display. Digit codes, decimal points and the blanking enable are snapshotted
// once per frame in LOAD; each digit gets a dark GUARD interval, then SHOW.
module seg_scan_ctrl #(
   parameter int unsigned DIV   = 100000,
   parameter int unsigned GUARD = 1000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] digits_in,
   input  logic [3:0]  dp_in,
   input  logic        lz_blank,
   output logic [3:0]  digit_code,
   output logic [3:0]  an,
   output logic        dp,
   output logic        frame_start
);

   localparam int unsigned MAXV   = (DIV > GUARD) ? ((DIV > 2) ? DIV : 2)
                                                  : ((GUARD > 2) ? GUARD : 2);
   localparam int unsigned CW     = $clog2(MAXV);
   localparam int unsigned D_LAST = DIV - 1;
   localparam int unsigned G_LAST = (GUARD > 0) ? (GUARD - 1) : 0;

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_GUARD = 2'd1,
      S_SHOW  = 2'd2
   } state_t;

   state_t         r_state, w_state_nxt;
   logic [1:0]     r_idx, w_idx_nxt;
   logic [CW-1:0]  r_cnt, w_cnt_nxt;
   logic [15:0]    r_snap_dig, w_snap_dig_nxt;
   logic [3:0]     r_snap_dp, w_snap_dp_nxt;
   logic           r_snap_lz, w_snap_lz_nxt;
   logic [3:0]     w_blank;
   logic [3:0]     w_an_nxt;
   logic [3:0]     w_code_nxt;
   logic           w_dp_nxt;
   logic           w_fs_nxt;

   // Next-state, counter and snapshot update; digits after a digit the
   // state advances on the last cycle of each interval.
   always_comb begin
      w_state_nxt    = r_state;
      w_idx_nxt      = r_idx;
      w_cnt_nxt      = r_cnt + CW'(1);
      w_snap_dig_nxt = r_snap_dig;
      w_snap_dp_nxt  = r_snap_dp;
      w_snap_lz_nxt  = r_snap_lz;
      case (r_state)
         S_LOAD: begin
            w_snap_dig_nxt = digits_in;
            w_snap_dp_nxt  = dp_in;
            w_snap_lz_nxt  = lz_blank;
            w_idx_nxt      = 2'd0;
            w_cnt_nxt      = '0;
            w_state_nxt    = (GUARD == 0) ? S_SHOW : S_GUARD;
         end
         S_GUARD: begin
            if (r_cnt == CW'(G_LAST)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_SHOW;
            end
         end
         S_SHOW: begin
            if (r_cnt == CW'(D_LAST)) begin
               w_cnt_nxt = '0;
               if (r_idx == 2'd3) begin
                  w_state_nxt = S_LOAD;
               end else begin
                  w_idx_nxt   = r_idx + 2'd1;
                  w_state_nxt = (GUARD == 0) ? S_SHOW : S_GUARD;
               end
            end
         end
         default: begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_LOAD;
         end
      endcase
   end

   // Leading-zero blanking from the snapshot that the next state will use.
   always_comb begin
      w_blank    = 4'b0000;
      w_blank[3] = w_snap_lz_nxt && (w_snap_dig_nxt[15:12] == 4'h0);
      w_blank[2] = w_blank[3] && (w_snap_dig_nxt[11:8] == 4'h0);
      w_blank[1] = w_blank[2] && (w_snap_dig_nxt[7:4] == 4'h0);
   end

   // Output values belonging to the state being entered on this edge.
   always_comb begin
      w_an_nxt   = 4'b1111;
      w_code_nxt = 4'hF;
      w_dp_nxt   = 1'b1;
      w_fs_nxt   = 1'b0;
      case (w_state_nxt)
         S_LOAD: w_fs_nxt = 1'b1;
         S_SHOW: begin
            if (!w_blank[w_idx_nxt]) begin
               w_an_nxt   = ~(4'b0001 << w_idx_nxt);
               w_code_nxt = w_snap_dig_nxt[{w_idx_nxt, 2'b00} +: 4];
               w_dp_nxt   = ~w_snap_dp_nxt[w_idx_nxt];
            end
         end
         default: ;
      endcase
   end

   // State, snapshot and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_LOAD;
         r_idx       <= 2'd0;
         r_cnt       <= '0;
         r_snap_dig  <= 16'h0000;
         r_snap_dp   <= 4'h0;
         r_snap_lz   <= 1'b0;
         an          <= 4'b1111;
         digit_code  <= 4'hF;
         dp          <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_idx       <= w_idx_nxt;
         r_cnt       <= w_cnt_nxt;
         r_snap_dig  <= w_snap_dig_nxt;
         r_snap_dp   <= w_snap_dp_nxt;
         r_snap_lz   <= w_snap_lz_nxt;
         an          <= w_an_nxt;
         digit_code  <= w_code_nxt;
         dp          <= w_dp_nxt;
         frame_start <= w_fs_nxt;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: two instances (DIV=4/GUARD=2 and DIV=1/GUARD=0)
// share stimulus and are compared against a frame-position reference model.
module tb_seg_scan_ctrl;

   localparam int unsigned DA = 4;
   localparam int unsigned GA = 2;
   localparam int unsigned DB = 1;
   localparam int unsigned GB = 0;
   localparam int unsigned FA = 1 + 4 * (GA + DA);
   localparam int unsigned FB = 1 + 4 * (GB + DB);

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic        lz_blank;
   logic [3:0]  code_a, an_a, code_b, an_b;
   logic        dp_a, fs_a, dp_b, fs_b;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   int unsigned n_cyc  = 0;

   logic [15:0] sd_a = '0, sd_b = '0;
   logic [3:0]  sdp_a = '0, sdp_b = '0;
   logic        slz_a = 1'b0, slz_b = 1'b0;

   always #5 clk = ~clk;

   seg_scan_ctrl #(.DIV(DA), .GUARD(GA)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
      .lz_blank(lz_blank), .digit_code(code_a), .an(an_a), .dp(dp_a),
      .frame_start(fs_a));

   seg_scan_ctrl #(.DIV(DB), .GUARD(GB)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .dp_in(dp_in),
      .lz_blank(lz_blank), .digit_code(code_b), .an(an_b), .dp(dp_b),
      .frame_start(fs_b));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, n_cyc, got, exp);
   endtask

   // Expected {frame_start, an, code, dp} for cycle n after reset.
   function automatic logic [9:0] model(input int unsigned n, input int unsigned g,
                                        input int unsigned d, input logic [15:0] sd,
                                        input logic [3:0] sdp, input logic slz);
      int unsigned f, p, k, idx, r;
      logic [3:0] a;
      f = 1 + 4 * (g + d);
      p = n % f;
      if (p == 0) return {(n != 0), 4'hF, 4'hF, 1'b1};
      k   = p - 1;
      idx = k / (g + d);
      r   = k % (g + d);
      if (r < g) return {1'b0, 4'hF, 4'hF, 1'b1};
      if (slz && idx > 0 && (sd >> (4 * idx)) == 16'h0) return {1'b0, 4'hF, 4'hF, 1'b1};
      a = 4'hF;
      a[idx] = 1'b0;
      return {1'b0, a, sd[4*idx +: 4], ~sdp[idx]};
   endfunction

   // Advance one clock: update the model at the edge, compare at the negedge.
   task automatic tick();
      logic [9:0] e;
      @(posedge clk);
      if (!rst_n) begin
         n_cyc = 0;
      end else begin
         if (n_cyc % FA == 0) begin sd_a = digits_in; sdp_a = dp_in; slz_a = lz_blank; end
         if (n_cyc % FB == 0) begin sd_b = digits_in; sdp_b = dp_in; slz_b = lz_blank; end
         n_cyc++;
      end
      @(negedge clk);
      e = model(n_cyc, GA, DA, sd_a, sdp_a, slz_a);
      check("a_fs",   32'(fs_a),   32'(e[9]));
      check("a_an",   32'(an_a),   32'(e[8:5]));
      check("a_code", 32'(code_a), 32'(e[4:1]));
      check("a_dp",   32'(dp_a),   32'(e[0]));
      check("a_an_onehot", 32'($countones(~an_a) <= 1), 32'd1);
      e = model(n_cyc, GB, DB, sd_b, sdp_b, slz_b);
      check("b_fs",   32'(fs_b),   32'(e[9]));
      check("b_an",   32'(an_b),   32'(e[8:5]));
      check("b_code", 32'(code_b), 32'(e[4:1]));
      check("b_dp",   32'(dp_b),   32'(e[0]));
      check("b_an_onehot", 32'($countones(~an_b) <= 1), 32'd1);
   endtask

   function automatic logic [3:0] rnd_nib();
      return ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
   endfunction

   initial begin
      rst_n     = 1'b0;
      digits_in = 16'h1234;
      dp_in     = 4'h0;
      lz_blank  = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;

      // Plain scan of 1234 without blanking.
      repeat (60) tick();

      // Leading-zero blanking on, then off.
      digits_in = 16'h0005; lz_blank = 1'b1; dp_in = 4'b0100;
      repeat (60) tick();
      lz_blank = 1'b0;
      repeat (60) tick();

      // Input change mid-frame must not tear the current frame.
      lz_blank = 1'b0; dp_in = 4'h0; digits_in = 16'h1111;
      while (n_cyc % FA != 10) tick();
      tick();
      digits_in = 16'h2222;
      repeat (50) tick();

      // One-cycle reset during SHOW(2) of the slow instance.
      while (n_cyc % FA != 16) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (40) tick();

      // Randomized inputs, with rare resets, over about 1000 slow frames.
      for (int i = 0; i < 1000 * int'(FA); i++) begin
         if ($urandom_range(0, 3) == 0) begin
            digits_in = {rnd_nib(), rnd_nib(), rnd_nib(), rnd_nib()};
            dp_in     = 4'($urandom_range(0, 15));
            lz_blank  = 1'($urandom_range(0, 1));
         end
         rst_n = ($urandom_range(0, 1999) == 0) ? 1'b0 : 1'b1;
         tick();
      end
      rst_n = 1'b1;
      repeat (30) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
